// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, hazard/branch controls in,
// IF/ID pipeline register and debug state out.
interface fetch_stage_if;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [63:0] redirect_target;
    logic [63:0] ifid_pc;
    logic [63:0] ifid_pc_plus4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic [31:0] fetch_count;
    logic        misalign_err;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  stall,
        input  flush,
        input  redirect,
        input  redirect_target,
        output ifid_pc,
        output ifid_pc_plus4,
        output ifid_instr,
        output ifid_valid,
        output fetch_count,
        output misalign_err
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output stall,
        output flush,
        output redirect,
        output redirect_target,
        input  ifid_pc,
        input  ifid_pc_plus4,
        input  ifid_instr,
        input  ifid_valid,
        input  fetch_count,
        input  misalign_err
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// registers the fetched instruction with its PC and PC+4 into IF/ID.
module fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter logic [31:0] NOP_INSTR  = 32'hD503201F,
    // Reset value of the delivered-instruction counter; nonzero only for debug preload.
    parameter logic [31:0] COUNT_INIT = 32'd0
) (
    input logic           clk,
    input logic           reset,
    fetch_stage_if.master bus
);
    logic [63:0] pc_p0;
    logic [63:0] ifid_pc_p1;
    logic [63:0] ifid_pc_plus4_p1;
    logic [31:0] ifid_instr_p1;
    logic        vld_p1;
    logic [31:0] fetch_count_q;
    logic        misalign_q;
    logic        load_bubble;
    logic        load_instr;

    function automatic logic [63:0] pc_inc(input logic [63:0] pc);
        return pc + 64'd4;
    endfunction

    function automatic logic [63:0] align_target(input logic [63:0] t);
        return {t[63:2], 2'b00};
    endfunction

    assign load_bubble = bus.redirect || bus.flush;
    assign load_instr  = !load_bubble && !bus.stall;

    // Stage p0: program counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_p0 <= RESET_PC;
        end else if (bus.redirect) begin
            pc_p0 <= align_target(bus.redirect_target);
        end else if (!bus.stall) begin
            pc_p0 <= pc_inc(pc_p0);
        end
    end

    // Stage p1: IF/ID register and debug state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_pc_p1       <= 64'd0;
            ifid_pc_plus4_p1 <= 64'd0;
            ifid_instr_p1    <= NOP_INSTR;
            vld_p1           <= 1'b0;
            fetch_count_q    <= COUNT_INIT;
            misalign_q       <= 1'b0;
        end else begin
            if (load_bubble) begin
                ifid_pc_p1       <= 64'd0;
                ifid_pc_plus4_p1 <= 64'd0;
                ifid_instr_p1    <= NOP_INSTR;
                vld_p1           <= 1'b0;
            end else if (load_instr) begin
                ifid_pc_p1       <= pc_p0;
                ifid_pc_plus4_p1 <= pc_inc(pc_p0);
                ifid_instr_p1    <= bus.imem_instr;
                vld_p1           <= 1'b1;
                fetch_count_q    <= fetch_count_q + 32'd1;
            end
            if (bus.redirect && (bus.redirect_target[1:0] != 2'b00)) begin
                misalign_q <= 1'b1;
            end
        end
    end

    assign bus.imem_addr     = pc_p0;
    assign bus.ifid_pc       = ifid_pc_p1;
    assign bus.ifid_pc_plus4 = ifid_pc_plus4_p1;
    assign bus.ifid_instr    = ifid_instr_p1;
    assign bus.ifid_valid    = vld_p1;
    assign bus.fetch_count   = fetch_count_q;
    assign bus.misalign_err  = misalign_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// control stimulus against a behavioural pipeline model.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'hD503201F;

    logic clk;
    logic reset;
    fetch_stage_if bus ();
    fetch_stage_if bus2 ();

    int vectors;
    int miscompares;

    // behavioural model state
    logic [63:0] m_pc, m_ipc, m_ipc4;
    logic [31:0] m_instr, m_cnt;
    logic        m_vld, m_err;

    fetch_stage dut (.clk(clk), .reset(reset), .bus(bus.master));
    fetch_stage #(.COUNT_INIT(32'hFFFF_FFFE)) dut2 (.clk(clk), .reset(reset), .bus(bus2.master));

    function automatic logic [31:0] imem(input logic [63:0] a);
        return 32'h1000_0000 + a[31:0];
    endfunction

    assign bus.imem_instr  = imem(bus.imem_addr);
    assign bus2.imem_instr = imem(bus2.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_pc = 64'd0; m_ipc = 64'd0; m_ipc4 = 64'd0;
        m_instr = NOP; m_vld = 1'b0; m_cnt = 32'd0; m_err = 1'b0;
    endfunction

    function automatic void model_bubble();
        m_ipc = 64'd0; m_ipc4 = 64'd0; m_instr = NOP; m_vld = 1'b0;
    endfunction

    // One clock edge of the fetch stage, by scenario.
    function automatic void model_edge(input logic s, input logic f, input logic r,
                                       input logic [63:0] t);
        if (r) begin
            model_bubble();
            m_pc = t & ~64'd3;
            if (t[1:0] != 2'b00) m_err = 1'b1;
        end else if (f) begin
            model_bubble();
            if (!s) m_pc = m_pc + 64'd4;
        end else if (!s) begin
            m_ipc = m_pc; m_ipc4 = m_pc + 64'd4; m_instr = imem(m_pc);
            m_vld = 1'b1; m_cnt = m_cnt + 32'd1; m_pc = m_pc + 64'd4;
        end
    endfunction

    task automatic step(input logic s, input logic f, input logic r, input logic [63:0] t);
        bus.stall = s; bus.flush = f; bus.redirect = r; bus.redirect_target = t;
        model_edge(s, f, r, t);
        @(posedge clk);
        #1;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect = 1'b0; bus.redirect_target = 64'd0;
    endtask

    task automatic do_reset();
        #3 reset = 1'b1;
        #2 reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (bus.imem_addr !== 64'd0) begin miscompares++; $display("FAIL reset_imem_addr got %h exp 0", bus.imem_addr); end
        vectors++; if (bus.ifid_pc !== 64'd0) begin miscompares++; $display("FAIL reset_ifid_pc got %h exp 0", bus.ifid_pc); end
        vectors++; if (bus.ifid_pc_plus4 !== 64'd0) begin miscompares++; $display("FAIL reset_ifid_pc_plus4 got %h exp 0", bus.ifid_pc_plus4); end
        vectors++; if (bus.ifid_instr !== NOP) begin miscompares++; $display("FAIL reset_ifid_instr got %h exp %h", bus.ifid_instr, NOP); end
        vectors++; if (bus.ifid_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ifid_valid got %b exp 0", bus.ifid_valid); end
        vectors++; if (bus.fetch_count !== 32'd0) begin miscompares++; $display("FAIL reset_fetch_count got %0d exp 0", bus.fetch_count); end
        vectors++; if (bus.misalign_err !== 1'b0) begin miscompares++; $display("FAIL reset_misalign_err got %b exp 0", bus.misalign_err); end
    endtask

    task automatic test_free_run();
        do_reset();
        step(0, 0, 0, 64'd0);
        vectors++; if (bus.ifid_pc !== 64'd0 || bus.ifid_valid !== 1'b1) begin miscompares++; $display("FAIL first_edge got pc=%h v=%b exp pc=0 v=1", bus.ifid_pc, bus.ifid_valid); end
        step(0, 0, 0, 64'd0);
        step(0, 0, 0, 64'd0);
        vectors++; if (bus.ifid_pc !== 64'd8) begin miscompares++; $display("FAIL run_ifid_pc got %h exp 8", bus.ifid_pc); end
        vectors++; if (bus.ifid_instr !== 32'h1000_0008) begin miscompares++; $display("FAIL run_ifid_instr got %h exp 10000008", bus.ifid_instr); end
        vectors++; if (bus.ifid_pc_plus4 !== 64'd12) begin miscompares++; $display("FAIL run_ifid_pc_plus4 got %h exp c", bus.ifid_pc_plus4); end
        vectors++; if (bus.fetch_count !== 32'd3) begin miscompares++; $display("FAIL run_fetch_count got %0d exp 3", bus.fetch_count); end
        vectors++; if (bus.imem_addr !== 64'd12) begin miscompares++; $display("FAIL run_imem_addr got %h exp c", bus.imem_addr); end
    endtask

    task automatic test_stall();
        do_reset();
        step(0, 0, 0, 64'd0);
        step(0, 0, 0, 64'd0);
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 64'd0);
            vectors++; if (bus.ifid_pc !== 64'd4) begin miscompares++; $display("FAIL stall_ifid_pc got %h exp 4", bus.ifid_pc); end
            vectors++; if (bus.imem_addr !== 64'd8) begin miscompares++; $display("FAIL stall_imem_addr got %h exp 8", bus.imem_addr); end
            vectors++; if (bus.fetch_count !== 32'd2) begin miscompares++; $display("FAIL stall_fetch_count got %0d exp 2", bus.fetch_count); end
        end
        step(0, 0, 0, 64'd0);
        vectors++; if (bus.ifid_pc !== 64'd8) begin miscompares++; $display("FAIL post_stall_ifid_pc got %h exp 8", bus.ifid_pc); end
    endtask

    task automatic test_redirect_stall();
        step(1, 0, 1, 64'h100);
        vectors++; if (bus.imem_addr !== 64'h100) begin miscompares++; $display("FAIL redir_imem_addr got %h exp 100", bus.imem_addr); end
        vectors++; if (bus.ifid_valid !== 1'b0) begin miscompares++; $display("FAIL redir_valid got %b exp 0", bus.ifid_valid); end
        vectors++; if (bus.ifid_instr !== NOP) begin miscompares++; $display("FAIL redir_instr got %h exp %h", bus.ifid_instr, NOP); end
        step(0, 0, 0, 64'd0);
        vectors++; if (bus.ifid_pc !== 64'h100 || bus.ifid_valid !== 1'b1) begin miscompares++; $display("FAIL redir_target got pc=%h v=%b exp pc=100 v=1", bus.ifid_pc, bus.ifid_valid); end
        vectors++; if (bus.ifid_instr !== 32'h1000_0100) begin miscompares++; $display("FAIL redir_target_instr got %h exp 10000100", bus.ifid_instr); end
    endtask

    task automatic test_misalign();
        step(0, 0, 1, 64'h103);
        vectors++; if (bus.imem_addr !== 64'h100) begin miscompares++; $display("FAIL misalign_imem_addr got %h exp 100", bus.imem_addr); end
        vectors++; if (bus.misalign_err !== 1'b1) begin miscompares++; $display("FAIL misalign_set got %b exp 1", bus.misalign_err); end
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 64'd0);
            vectors++; if (bus.misalign_err !== 1'b1) begin miscompares++; $display("FAIL misalign_sticky edge %0d got %b exp 1", i, bus.misalign_err); end
        end
        do_reset();
        vectors++; if (bus.misalign_err !== 1'b0) begin miscompares++; $display("FAIL misalign_clear got %b exp 0", bus.misalign_err); end
    endtask

    task automatic test_flush_stall();
        logic [31:0] cnt0;
        step(0, 0, 1, 64'h20);
        cnt0 = bus.fetch_count;
        step(1, 1, 0, 64'd0);
        vectors++; if (bus.ifid_valid !== 1'b0 || bus.ifid_instr !== NOP) begin miscompares++; $display("FAIL flush_stall_bubble got v=%b i=%h exp v=0 i=%h", bus.ifid_valid, bus.ifid_instr, NOP); end
        vectors++; if (bus.imem_addr !== 64'h20) begin miscompares++; $display("FAIL flush_stall_pc got %h exp 20", bus.imem_addr); end
        step(0, 0, 0, 64'd0);
        vectors++; if (bus.ifid_pc !== 64'h20 || bus.ifid_valid !== 1'b1) begin miscompares++; $display("FAIL flush_refetch got pc=%h v=%b exp pc=20 v=1", bus.ifid_pc, bus.ifid_valid); end
        vectors++; if (bus.fetch_count !== cnt0 + 32'd1) begin miscompares++; $display("FAIL flush_count got %0d exp %0d", bus.fetch_count, cnt0 + 32'd1); end
        step(0, 1, 0, 64'd0);
        vectors++; if (bus.ifid_valid !== 1'b0 || bus.imem_addr !== 64'h28) begin miscompares++; $display("FAIL flush_alone got v=%b pc=%h exp v=0 pc=28", bus.ifid_valid, bus.imem_addr); end
    endtask

    task automatic test_pc_wrap();
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        step(0, 0, 0, 64'd0);
        vectors++; if (bus.ifid_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin miscompares++; $display("FAIL wrap_ifid_pc got %h exp fffffffffffffffc", bus.ifid_pc); end
        vectors++; if (bus.ifid_pc_plus4 !== 64'd0) begin miscompares++; $display("FAIL wrap_pc_plus4 got %h exp 0", bus.ifid_pc_plus4); end
        vectors++; if (bus.imem_addr !== 64'd0) begin miscompares++; $display("FAIL wrap_imem_addr got %h exp 0", bus.imem_addr); end
    endtask

    task automatic test_count_wrap();
        do_reset();
        vectors++; if (bus2.fetch_count !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL cnt_preload got %h exp fffffffe", bus2.fetch_count); end
        step(0, 0, 0, 64'd0);
        vectors++; if (bus2.fetch_count !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL cnt_max got %h exp ffffffff", bus2.fetch_count); end
        step(0, 0, 0, 64'd0);
        vectors++; if (bus2.fetch_count !== 32'd0) begin miscompares++; $display("FAIL cnt_wrap got %h exp 0", bus2.fetch_count); end
        step(0, 0, 0, 64'd0);
        vectors++; if (bus2.fetch_count !== 32'd1) begin miscompares++; $display("FAIL cnt_after_wrap got %h exp 1", bus2.fetch_count); end
    endtask

    task automatic test_async_reset();
        step(0, 0, 1, 64'h3);
        step(0, 0, 0, 64'd0);
        step(0, 0, 0, 64'd0);
        bus.stall = 1'b1; bus.redirect = 1'b1; bus.redirect_target = 64'h500;
        #2 reset = 1'b1;
        #1;
        vectors++; if (bus.imem_addr !== 64'd0 || bus.ifid_pc !== 64'd0 || bus.ifid_pc_plus4 !== 64'd0)
            begin miscompares++; $display("FAIL async_reset_pc got a=%h p=%h p4=%h exp 0", bus.imem_addr, bus.ifid_pc, bus.ifid_pc_plus4); end
        vectors++; if (bus.ifid_instr !== NOP || bus.ifid_valid !== 1'b0) begin miscompares++; $display("FAIL async_reset_ifid got i=%h v=%b exp i=%h v=0", bus.ifid_instr, bus.ifid_valid, NOP); end
        vectors++; if (bus.fetch_count !== 32'd0 || bus.misalign_err !== 1'b0) begin miscompares++; $display("FAIL async_reset_dbg got c=%0d e=%b exp 0 0", bus.fetch_count, bus.misalign_err); end
        bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_target = 64'd0;
        #1 reset = 1'b0;
        model_reset();
        step(0, 0, 0, 64'd0);
        vectors++; if (bus.ifid_pc !== 64'd0 || bus.ifid_valid !== 1'b1 || bus.imem_addr !== 64'd4)
            begin miscompares++; $display("FAIL post_async_reset got p=%h v=%b a=%h exp p=0 v=1 a=4", bus.ifid_pc, bus.ifid_valid, bus.imem_addr); end
    endtask

    task automatic test_random();
        logic s, f, r;
        logic [63:0] t;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 7) == 0);
            t = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 | {60'd0, t[3:0]};
            else if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
            step(s, f, r, t);
            vectors++; if (bus.imem_addr !== m_pc) begin miscompares++; $display("FAIL rand_imem_addr @%0d got %h exp %h", i, bus.imem_addr, m_pc); end
            vectors++; if (bus.ifid_pc !== m_ipc) begin miscompares++; $display("FAIL rand_ifid_pc @%0d got %h exp %h", i, bus.ifid_pc, m_ipc); end
            vectors++; if (bus.ifid_pc_plus4 !== m_ipc4) begin miscompares++; $display("FAIL rand_ifid_pc_plus4 @%0d got %h exp %h", i, bus.ifid_pc_plus4, m_ipc4); end
            vectors++; if (bus.ifid_instr !== m_instr) begin miscompares++; $display("FAIL rand_ifid_instr @%0d got %h exp %h", i, bus.ifid_instr, m_instr); end
            vectors++; if (bus.ifid_valid !== m_vld) begin miscompares++; $display("FAIL rand_ifid_valid @%0d got %b exp %b", i, bus.ifid_valid, m_vld); end
            vectors++; if (bus.fetch_count !== m_cnt) begin miscompares++; $display("FAIL rand_fetch_count @%0d got %0d exp %0d", i, bus.fetch_count, m_cnt); end
            vectors++; if (bus.misalign_err !== m_err) begin miscompares++; $display("FAIL rand_misalign_err @%0d got %b exp %b", i, bus.misalign_err, m_err); end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect = 1'b0; bus.redirect_target = 64'd0;
        bus2.stall = 1'b0; bus2.flush = 1'b0; bus2.redirect = 1'b0; bus2.redirect_target = 64'd0;
        model_reset();
        #1;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_stall();
        test_misalign();
        test_flush_stall();
        test_pc_wrap();
        test_count_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined CPU: owns the program counter, drives the instruction-memory address, and registers the fetched instruction with its PC and PC+4 into the IF/ID pipeline register. It sits directly upstream of the decode stage. It accepts stall and flush requests from hazard logic and PC redirects from branch resolution. It also keeps a delivered-instruction counter and a sticky misaligned-redirect flag for debug.

## Interface
- RESET_PC, 64'd0, PC value loaded on reset; must be 4-byte aligned.
- NOP_INSTR, 32'hD503201F, encoding placed in IF/ID on a bubble.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- imem_addr  out  64  current PC, fed to instruction memory.
- imem_instr  in  32  instruction memory read data; combinational from imem_addr within the same cycle.
- stall  in  1  hold PC and IF/ID contents.
- flush  in  1  load a bubble into IF/ID at the next edge.
- redirect  in  1  load redirect_target into PC; squash the instruction currently being fetched.
- redirect_target  in  64  new PC for redirect.
- ifid_pc  out  64  PC of the registered instruction.
- ifid_pc_plus4  out  64  ifid_pc + 4.
- ifid_instr  out  32  registered instruction.
- ifid_valid  out  1  1 = real instruction, 0 = bubble.
- fetch_count  out  32  number of valid instructions loaded into IF/ID.
- misalign_err  out  1  sticky flag: a redirect target had nonzero bits [1:0].

## Operation
- Next-PC priority, highest first: reset, redirect, stall, normal.
  - Reset: PC = RESET_PC.
  - Redirect: PC = {redirect_target[63:2], 2'b00}.
  - Stall: PC holds.
  - Normal: PC + 4.
- IF/ID update priority, highest first: reset, redirect, flush, stall, normal.
  - Reset, redirect, or flush: bubble. ifid_instr = NOP_INSTR, ifid_valid = 0, ifid_pc = 0, ifid_pc_plus4 = 0.
  - Stall: IF/ID holds.
  - Normal: ifid_instr = imem_instr, ifid_pc = PC, ifid_pc_plus4 = PC + 4, ifid_valid = 1.
- Stall and flush together: IF/ID takes a bubble and PC holds. The held instruction is refetched later.
- Stall and redirect together: redirect wins on both PC and IF/ID.
- Flush alone: IF/ID takes a bubble and PC advances. The dropped instruction is treated as wrong-path.
- fetch_count increments by 1 on every edge where IF/ID is loaded with ifid_valid = 1. It wraps from 32'hFFFF_FFFF to 0.
- misalign_err is set on any edge where redirect = 1 and redirect_target[1:0] != 0. It is cleared only by reset.
- PC arithmetic is modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0. ifid_pc_plus4 wraps the same way.
- Decode must qualify all register writes, memory writes and flag updates with ifid_valid.

## Timing
- Reset values, asserted asynchronously:
  - imem_addr = RESET_PC.
  - ifid_pc = 0, ifid_pc_plus4 = 0.
  - ifid_instr = NOP_INSTR, ifid_valid = 0.
  - fetch_count = 0, misalign_err = 0.
- Fetch latency is 1 cycle. The instruction at PC appears on the ifid_* outputs after the first posedge following the cycle in which imem_addr = PC.
- First edge after reset deasserts: IF/ID = instr@RESET_PC with valid = 1, and PC = RESET_PC + 4.
- Redirect sampled at edge n:
  - Edge n: PC = target, IF/ID = bubble.
  - Edge n+1: IF/ID = instr@target.
  - Redirect penalty at this stage is one bubble.
- Stall sampled at edge n: all outputs unchanged after edge n. No partial updates.
- Reset asserted mid-stream, including during a stall or redirect: all outputs go to their reset values immediately. Pending redirect and stall are discarded.
- stall, flush, redirect and redirect_target are sampled only at posedge. Their combinational values do not affect outputs until then.

## Test plan
- Reset then free-run with RESET_PC = 0 and imem returning 32'h1000_0000 + addr → after 3 edges: ifid_pc = 8, ifid_instr = 32'h1000_0008, ifid_pc_plus4 = 12, fetch_count = 3, imem_addr = 12.
- Stall held for 2 edges starting at PC = 8 → ifid_pc stays at 4 and imem_addr stays at 8 for both edges. fetch_count does not change. The next normal edge gives ifid_pc = 8.
- Redirect to 64'h100 and assert stall in the same cycle → after the edge: imem_addr = 64'h100, ifid_valid = 0, ifid_instr = 32'hD503201F. After the next edge: ifid_pc = 64'h100, valid = 1.
- Redirect to 64'h103 → imem_addr = 64'h100 and misalign_err = 1. misalign_err stays 1 through 10 further edges and clears only on reset.
- Flush with stall at PC = 64'h20 → IF/ID is a bubble and PC stays at 64'h20. Next edge: ifid_pc = 64'h20, valid = 1, and fetch_count is incremented exactly once for that instruction.
- Wrap cases, plus reset asserted asynchronously between edges:
  - Redirect to 64'hFFFF_FFFF_FFFF_FFFC then run → the following edge gives ifid_pc_plus4 = 0 and imem_addr = 0.
  - Preload fetch_count near 32'hFFFF_FFFF → it wraps to 0.
  - Reset asserted between edges → outputs reach their reset values with no clock edge required.
